// File: rtl/mips_mmio_ctrl_if.sv
// CPU-side memory bus control signals shared by the CPU, the RAM and the MMIO controller.
//   CS     : chip select driven by the CPU
//   WE     : write enable driven by the CPU
//   ADDR   : 7-bit word address driven by the CPU
//   RAM_CS : chip select forwarded to the RAM by the MMIO controller
// The 32-bit data bus is tri-stated and stays a plain inout port on the controller.
interface mips_mmio_ctrl_if;
  logic       CS;
  logic       WE;
  logic [6:0] ADDR;
  logic       RAM_CS;

  modport master (output CS, output WE, output ADDR, input RAM_CS);
  modport slave  (input CS, input WE, input ADDR, output RAM_CS);
endinterface

// File: rtl/mips_mmio_ctrl.sv
// Memory-mapped I/O controller on the shared CPU memory bus.
// Word addresses at or above IO_BASE are served locally (LED, switches, timer, status, halt);
// everything below is passed through to the RAM via RAM_CS.
//   CLK      : system clock
//   RST      : synchronous active-high reset
//   bus      : CS/WE/ADDR from the CPU, RAM_CS to the RAM
//   Mem_Bus  : shared 32-bit data bus, driven here only on I/O reads
//   SW       : asynchronous switches (synchronised)
//   HALT_REQ : asynchronous halt button (synchronised)
//   LED      : LED register
//   HALT     : sticky halt flag to the CPU
module mips_mmio_ctrl #(
  parameter logic [6:0]  IO_BASE     = 7'h78,
  parameter int unsigned LED_W       = 16,
  parameter int unsigned SW_W        = 16,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic                 CLK,
  input  logic                 RST,
  mips_mmio_ctrl_if.slave      bus,
  inout  wire  [31:0]          Mem_Bus,
  input  logic [SW_W-1:0]      SW,
  input  logic                 HALT_REQ,
  output logic [LED_W-1:0]     LED,
  output logic                 HALT
);

  // Address decode
  logic       io_sel;
  logic [6:0] off;
  logic       wr_en, rd_en;
  logic       wr_led, wr_tctrl, wr_tcmp, wr_status, wr_halt;
  logic [31:0] wdata;

  assign io_sel    = (bus.ADDR >= IO_BASE);
  assign off       = bus.ADDR - IO_BASE;
  assign wr_en     = bus.CS & bus.WE & io_sel;
  assign rd_en     = bus.CS & ~bus.WE & io_sel;
  assign wdata     = Mem_Bus;
  assign wr_led    = wr_en && (off == 7'd0);
  assign wr_tctrl  = wr_en && (off == 7'd3);
  assign wr_tcmp   = wr_en && (off == 7'd4);
  assign wr_status = wr_en && (off == 7'd5);
  assign wr_halt   = wr_en && (off == 7'd6);

  assign bus.RAM_CS = bus.CS & ~io_sel;

  // Synchronisers
  logic [SYNC_STAGES-1:0][SW_W-1:0] sw_sync_q;
  logic [SYNC_STAGES-1:0]           hreq_sync_q;
  logic [SW_W-1:0]                  sw_synced;
  logic                             hreq_synced;

  always_ff @(posedge CLK) begin
    if (RST) begin
      sw_sync_q   <= '0;
      hreq_sync_q <= '0;
    end else begin
      sw_sync_q   <= {sw_sync_q[SYNC_STAGES-2:0], SW};
      hreq_sync_q <= {hreq_sync_q[SYNC_STAGES-2:0], HALT_REQ};
    end
  end

  assign sw_synced   = sw_sync_q[SYNC_STAGES-1];
  assign hreq_synced = hreq_sync_q[SYNC_STAGES-1];

  // Registers
  logic [LED_W-1:0] led_q, led_d;
  logic             halt_q, halt_d, halt_vis;
  logic [31:0]      tcount_q, tcount_d;
  logic [31:0]      tcmp_q, tcmp_d;
  logic             en_q, en_d;
  logic             wrap_q, wrap_d;
  logic             tmatch, tclr;

  // The synced request is OR-ed straight into HALT so it is visible as soon as it leaves the
  // synchroniser; halt_q then holds it once the button is released.
  assign halt_vis = halt_q | hreq_synced;

  always_comb begin
    led_d    = led_q;
    halt_d   = halt_vis | (wr_halt & wdata[0]);
    tcmp_d   = tcmp_q;
    en_d     = en_q;
    tcount_d = tcount_q;
    wrap_d   = wrap_q;
    tmatch   = en_q && (tcount_q == tcmp_q);
    tclr     = wr_tctrl && wdata[1];

    if (wr_led)   led_d  = wdata[LED_W-1:0];
    if (wr_tcmp)  tcmp_d = wdata;
    if (wr_tctrl) en_d   = wdata[0];

    // CLR write outranks a compare match; match outranks plain counting.
    if (tclr) begin
      tcount_d = '0;
    end else if (tmatch) begin
      tcount_d = '0;
    end else if (en_q) begin
      tcount_d = tcount_q + 32'd1;
    end

    // Set wins over a coincident write-1-to-clear.
    if (wr_status && wdata[0]) wrap_d = 1'b0;
    if (tmatch && !tclr)       wrap_d = 1'b1;
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      led_q    <= '0;
      halt_q   <= 1'b0;
      tcount_q <= '0;
      tcmp_q   <= 32'hFFFF_FFFF;
      en_q     <= 1'b0;
      wrap_q   <= 1'b0;
    end else begin
      led_q    <= led_d;
      halt_q   <= halt_d;
      tcount_q <= tcount_d;
      tcmp_q   <= tcmp_d;
      en_q     <= en_d;
      wrap_q   <= wrap_d;
    end
  end

  // Read mux: reflects register state at the start of the cycle.
  logic [31:0] rdata;

  always_comb begin
    rdata = '0;
    unique case (off)
      7'd0:    rdata[LED_W-1:0] = led_q;
      7'd1:    rdata[SW_W-1:0]  = sw_synced;
      7'd2:    rdata            = tcount_q;
      7'd3:    rdata[0]         = en_q;
      7'd4:    rdata            = tcmp_q;
      7'd5:    rdata[1:0]       = {halt_vis, wrap_q};
      7'd6:    rdata[0]         = halt_vis;
      default: rdata            = '0;
    endcase
  end

  assign Mem_Bus = rd_en ? rdata : 32'bz;
  assign LED     = led_q;
  assign HALT    = halt_vis;

endmodule

// File: tb/tb_mips_mmio_ctrl.sv
// Scoreboard bench for mips_mmio_ctrl: a driver applies one bus cycle at a time and pushes the
// expected outputs from a behavioural model; a monitor pops and compares on the falling edge.
module tb_mips_mmio_ctrl;
  localparam int SYNC = 2;

  logic        CLK = 1'b0;
  logic        RST;
  logic [15:0] SW;
  logic        HALT_REQ;
  logic [15:0] LED;
  logic        HALT;
  wire  [31:0] mem_bus;
  logic        drv_en;
  logic [31:0] drv_val;

  always #5 CLK = ~CLK;

  assign mem_bus = drv_en ? drv_val : 32'bz;

  mips_mmio_ctrl_if bus_if ();

  mips_mmio_ctrl dut (
    .CLK      (CLK),
    .RST      (RST),
    .bus      (bus_if),
    .Mem_Bus  (mem_bus),
    .SW       (SW),
    .HALT_REQ (HALT_REQ),
    .LED      (LED),
    .HALT     (HALT)
  );

  typedef struct {
    int          id;
    logic        chk_bus;
    logic [31:0] bus;
    logic        ram_cs;
    logic [15:0] led;
    logic        halt;
  } exp_t;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_errors = 0;
  int   cyc_id   = 0;

  // Behavioural model state
  logic [15:0] m_led;
  logic        m_halt;
  logic [31:0] m_tcount, m_tcmp;
  logic        m_en, m_wrap;
  logic [15:0] m_sw_hist[$];
  logic        m_hq_hist[$];

  function automatic void model_reset();
    m_led = 0; m_halt = 0; m_tcount = 0; m_tcmp = 32'hFFFF_FFFF; m_en = 0; m_wrap = 0;
    m_sw_hist = {};
    m_hq_hist = {};
    for (int i = 0; i < SYNC; i++) begin
      m_sw_hist.push_back(16'h0);
      m_hq_hist.push_back(1'b0);
    end
  endfunction

  function automatic logic m_halt_vis();
    return m_halt | m_hq_hist[SYNC-1];
  endfunction

  function automatic logic [31:0] m_read(int o);
    case (o)
      0: return {16'h0, m_led};
      1: return {16'h0, m_sw_hist[SYNC-1]};
      2: return m_tcount;
      3: return {31'h0, m_en};
      4: return m_tcmp;
      5: return {30'h0, m_halt_vis(), m_wrap};
      6: return {31'h0, m_halt_vis()};
      default: return 32'h0;
    endcase
  endfunction

  function automatic void model_step(bit rst, bit cs, bit we, logic [6:0] addr,
                                     logic [31:0] wd, logic [15:0] sw, bit hreq);
    bit wr, match, clr;
    int o;
    if (rst) begin
      model_reset();
      return;
    end
    o     = int'(addr) - 'h78;
    wr    = cs && we && (addr >= 7'h78);
    match = m_en && (m_tcount == m_tcmp);
    clr   = wr && o == 3 && wd[1];
    m_halt = m_halt_vis() | (wr && o == 6 && wd[0]);
    if (clr)                       m_tcount = 0;
    else if (match)                m_tcount = 0;
    else if (m_en)                 m_tcount = m_tcount + 1;
    if (wr && o == 5 && wd[0])     m_wrap = 0;
    if (match && !clr)             m_wrap = 1;
    if (wr && o == 3)              m_en = wd[0];
    if (wr && o == 4)              m_tcmp = wd;
    if (wr && o == 0)              m_led = wd[15:0];
    m_sw_hist.push_front(sw);
    void'(m_sw_hist.pop_back());
    m_hq_hist.push_front(hreq);
    void'(m_hq_hist.pop_back());
  endfunction

  function automatic logic [31:0] ram_val(logic [6:0] a);
    return 32'hC0DE_0000 ^ {25'h0, a};
  endfunction

  // One bus cycle: drive, record expectations, then advance the model across the edge.
  task automatic cycle(input bit rst, input bit cs, input bit we, input logic [6:0] addr,
                       input logic [31:0] wd, input logic [15:0] sw, input bit hreq,
                       input bit chk);
    exp_t e;
    bit   io;
    io          = (addr >= 7'h78);
    RST         = rst;
    bus_if.CS   = cs;
    bus_if.WE   = we;
    bus_if.ADDR = addr;
    SW          = sw;
    HALT_REQ    = hreq;
    drv_en      = 1'b0;
    drv_val     = wd;
    e.bus       = 32'h0;
    if (cs && we) begin
      drv_en = 1'b1;
      e.bus  = wd;
    end else if (cs && !io) begin
      drv_en  = 1'b1;
      drv_val = ram_val(addr);
      e.bus   = ram_val(addr);
    end else if (cs) begin
      e.bus = m_read(int'(addr) - 'h78);
    end
    e.id      = cyc_id;
    e.chk_bus = cs;
    e.ram_cs  = cs && !io;
    e.led     = m_led;
    e.halt    = m_halt_vis();
    if (chk) sb.push_back(e);
    cyc_id++;
    @(posedge CLK);
    model_step(rst, cs, we, addr, wd, sw, hreq);
    #1;
  endtask

  task automatic wr(input logic [6:0] a, input logic [31:0] d);
    cycle(0, 1, 1, a, d, SW, 0, 1);
  endtask

  task automatic rd(input logic [6:0] a);
    cycle(0, 1, 0, a, 32'h0, SW, 0, 1);
  endtask

  task automatic idle();
    cycle(0, 0, 0, 7'h00, 32'h0, SW, 0, 1);
  endtask

  // Monitor
  always @(negedge CLK) begin
    if (sb.size() != 0) begin
      exp_t e;
      e = sb.pop_front();
      if (e.chk_bus) begin
        n_checks++;
        if (mem_bus !== e.bus) begin
          n_errors++;
          $display("FAIL bus cyc=%0d addr=%h we=%b got=%h exp=%h", e.id, bus_if.ADDR,
                   bus_if.WE, mem_bus, e.bus);
        end
      end
      n_checks++;
      if (bus_if.RAM_CS !== e.ram_cs) begin
        n_errors++;
        $display("FAIL ram_cs cyc=%0d got=%b exp=%b", e.id, bus_if.RAM_CS, e.ram_cs);
      end
      n_checks++;
      if (LED !== e.led) begin
        n_errors++;
        $display("FAIL led cyc=%0d got=%h exp=%h", e.id, LED, e.led);
      end
      n_checks++;
      if (HALT !== e.halt) begin
        n_errors++;
        $display("FAIL halt cyc=%0d got=%b exp=%b", e.id, HALT, e.halt);
      end
    end
  end

  initial begin
    logic [6:0]  a;
    logic [31:0] d;
    int          wait_cnt;
    model_reset();
    RST = 1; bus_if.CS = 0; bus_if.WE = 0; bus_if.ADDR = 0; SW = 0; HALT_REQ = 0;
    drv_en = 0; drv_val = 0;
    @(posedge CLK); #1;
    cycle(1, 0, 0, 7'h00, 32'h0, 16'h0, 0, 0);
    cycle(1, 0, 0, 7'h00, 32'h0, 16'h0, 0, 1);

    // RAM passthrough, then I/O decode
    rd(7'h10);
    rd(7'h77);
    rd(7'h78);

    // LED
    wr(7'h78, 32'h0000_ABCD);
    rd(7'h78);
    cycle(1, 0, 0, 7'h00, 32'h0, SW, 0, 1);
    rd(7'h78);

    // Switch synchroniser latency
    SW = 16'h00F3;
    for (int i = 0; i < 4; i++) rd(7'h79);

    // Timer wrap with TCMP=5
    wr(7'h7C, 32'd5);
    wr(7'h7B, 32'd1);
    for (int i = 0; i < 8; i++) rd(7'h7A);
    rd(7'h7D);
    wr(7'h7D, 32'h1);
    rd(7'h7D);
    for (int i = 0; i < 8; i++) wr(7'h7D, 32'h1);  // sweeps a W1C across a match edge
    rd(7'h7D);
    wr(7'h7D, 32'h0);
    rd(7'h7D);

    // CLR
    wr(7'h7C, 32'd100);
    wr(7'h7B, 32'h3);
    idle(); idle();
    rd(7'h7A);
    wr(7'h7B, 32'h3);
    rd(7'h7A); rd(7'h7A);
    wr(7'h7B, 32'h0);
    rd(7'h7A); rd(7'h7A); rd(7'h7B);

    // TCMP=0 with EN=1
    wr(7'h7C, 32'd0);
    wr(7'h7B, 32'h1);
    wr(7'h7D, 32'h1);
    rd(7'h7D); rd(7'h7A);

    // HALT by write, then by request pin
    wr(7'h7E, 32'h0);
    rd(7'h7E);
    wr(7'h7E, 32'h1);
    rd(7'h7E); rd(7'h7D);
    cycle(1, 0, 0, 7'h00, 32'h0, SW, 0, 1);
    rd(7'h7E);
    for (int i = 0; i < 3; i++) cycle(0, 1, 0, 7'h7E, 32'h0, SW, 1, 1);
    for (int i = 0; i < 3; i++) rd(7'h7E);
    rd(7'h7F);
    wr(7'h7F, 32'hFFFF_FFFF);
    rd(7'h7F);
    cycle(1, 1, 1, 7'h78, 32'h1234, SW, 0, 1);  // write under reset is dropped
    rd(7'h78);

    // Randomised traffic
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 3) != 0) a = 7'h78 + 7'($urandom_range(0, 7));
      else a = 7'($urandom_range(0, 'h77));
      d = $urandom;
      if (a == 7'h7C && $urandom_range(0, 1) == 1) d = $urandom_range(0, 20);
      if (a == 7'h7E) d[0] = ($urandom_range(0, 15) == 0);
      if ($urandom_range(0, 9) == 0) SW = 16'($urandom);
      cycle($urandom_range(0, 99) == 0, $urandom_range(0, 4) != 0, $urandom_range(0, 1) == 1,
            a, d, SW, $urandom_range(0, 199) == 0, 1);
    end

    idle();
    wait_cnt = 0;
    while (sb.size() != 0 && wait_cnt < 10) begin
      @(posedge CLK);
      wait_cnt++;
    end
    if (sb.size() != 0) begin
      n_errors++;
      $display("FAIL drain pending=%0d required=0", sb.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/mips_mmio_ctrl.md
Name: mips_mmio_ctrl

Overview:
Memory-mapped I/O controller on the processor's shared Mem_Bus, directly downstream of the multicycle CPU and beside the 128-word RAM. It decodes the 7-bit word address and splits accesses. The low region passes through to RAM. The top of the map is served locally by LED, switch, timer, status and HALT registers. HALT drives the CPU clock-enable/halt input at the top level.

Parameters:
IO_BASE, 7'h78, first word address claimed by this block (0x78..0x7F)
LED_W, 16, width of LED output register
SW_W, 16, width of switch input
SYNC_STAGES, 2, flip-flop stages on SW and HALT_REQ inputs (min 2)

Ports:
CLK  input  1  system clock; all state updates on posedge CLK
RST  input  1  reset, synchronous, active-high
CS  input  1  CPU chip select (same signal CPU drives to RAM)
WE  input  1  CPU write enable
ADDR  input  7  CPU word address
Mem_Bus  inout  32  shared data bus; driven by this block only on I/O reads
RAM_CS  output  1  chip select forwarded to RAM = CS & ~io_sel
SW  input  SW_W  asynchronous board switches
HALT_REQ  input  1  asynchronous halt button, active-high
LED  output  LED_W  LED register
HALT  output  1  sticky halt flag to CPU

Behaviour:
- io_sel = (ADDR >= IO_BASE). Combinational: RAM_CS goes low for I/O addresses in the same cycle CS rises.
- Map (offset from IO_BASE):
  - 0: LED, RW, bits [LED_W-1:0], upper bits read 0.
  - 1: SW, RO, synced value, zero-extended.
  - 2: TCOUNT, RO, 32-bit.
  - 3: TCTRL. Bit0 EN is RW. Bit1 CLR is write-only and reads 0.
  - 4: TCMP, RW, 32-bit.
  - 5: STATUS. Bit0 WRAP is sticky and write-1-to-clear. Bit1 HALT is RO.
  - 6: HALT. Writing bit0=1 sets HALT. Writing 0 has no effect. Reads {31'b0,HALT}.
  - 7: unmapped. Reads 0; writes ignored.
- Writes: register updated at posedge CLK when CS&WE&io_sel. The CPU holds CS/WE/ADDR/data stable through that edge, so write latency is 1 cycle.
- Reads: Mem_Bus = selected register value combinationally while CS&~WE&io_sel; otherwise high-Z. The block never drives the bus when WE=1 or CS=0. A value read in the CPU's lw final cycle reflects register state at the start of that cycle.
- Synchronizers: SW and HALT_REQ each pass through SYNC_STAGES flops. SW read latency from pin is SYNC_STAGES cycles.
- HALT: set by a synced HALT_REQ=1 or by a write to offset 6. It is cleared only by RST.
- Timer, priority per posedge:
  1. RST
  2. CLR write: TCOUNT <= 0. EN is taken from the same write data.
  3. EN=1 and TCOUNT==TCMP: TCOUNT <= 0, WRAP <= 1.
  4. EN=1: TCOUNT <= TCOUNT+1, wrapping mod 2^32.
  5. Otherwise TCOUNT holds.
- TCMP rules:
  - TCMP=0 with EN=1: WRAP is set every cycle and TCOUNT stays 0.
  - Writing TCMP below the current TCOUNT: no match until TCOUNT wraps through 2^32.
- WRAP: a W1C on the same edge as a new match leaves WRAP=1 (set wins). A W1C write of 0 has no effect.
- Reset values: LED=0, HALT=0, TCOUNT=0, EN=0, TCMP=32'hFFFFFFFF, WRAP=0, all sync flops=0. Mem_Bus is Z during reset unless an I/O read is selected.
- Reset mid-access: a write coincident with RST is discarded. Reads remain combinational.
- Addresses below IO_BASE: the block never drives Mem_Bus and never updates registers; the RAM handles the access.

Test Plan:
- RAM passthrough: CS=1, WE=0, ADDR=7'h10 -> RAM_CS=1, Mem_Bus not driven by block. Then ADDR=7'h78 -> RAM_CS=0.
- LED: sw 32'h0000ABCD to 0x78 -> LED=16'hABCD after that posedge. lw 0x78 returns 32'h0000ABCD. RST -> LED=0.
- Switch sync: SW=16'h00F3 -> lw 0x79 returns 0 until 2 posedges elapse, then 32'h000000F3.
- Timer wrap:
  - Setup: TCMP=5, then TCTRL=1.
  - TCOUNT sequence 0,1,2,3,4,5,0; WRAP=1 on the cycle TCOUNT returns to 0; lw 0x7D reads 1.
  - W1C with bit0=1 -> WRAP=0.
  - W1C on the same edge as a match -> WRAP stays 1.
- CLR: with EN=1 and TCOUNT=3, write TCTRL=32'h3 -> TCOUNT=0 next cycle and counting continues. Write TCTRL=0 -> TCOUNT holds its value.
- HALT:
  - sw 1 to 0x7E -> HALT=1 and stays 1.
  - sw 0 to 0x7E -> no change; RST -> 0.
  - HALT_REQ pulse ≥3 cycles -> HALT=1 after 2 posedges.
  - lw 0x7F -> 0.
